midori_affine_stage: RTL
========================

// Module: midori_affine_stage
// PURPOSE
//  Registered, N-nibble, d-share Midori affine layer with valid/ready flow control.
//  Applies one of three per-share affine maps to every nibble of every share, selected per transfer by mode:
//   - input affine
//   - output affine
//   - middle affine
//  Sits between masked S-box stages as a glitch-isolating pipeline register.
//  The affine constant is injected into exactly one share, so the unshared value stays correct.
// PARAMETERS
//  NIBBLES          16          nibbles per share (state width W = 4*NIBBLES)
//  SHARES           3           number of Boolean shares, >= 2
//  OUT_CONST_SHARE  SHARES-1    share index that receives the output-affine constant
//  MID_CONST_SHARE  0           share index that receives the middle-affine constant
//  CNT_W            16          width of the accepted-transfer counter
// PORTS
//  clk         in   1           clock, rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  mode_i      in   2           00 bypass, 01 input affine, 10 output affine, 11 middle affine
//  in_valid    in   1           input shares valid
//  in_ready    out  1           stage can accept this cycle
//  in_shares   in   SHARES*W    share s at [s*W +: W]; nibble n at [s*W+4n +: 4]
//  out_valid   out  1           out_shares holds a result
//  out_ready   in   1           downstream accepts
//  out_shares  out  SHARES*W    same packing as in_shares
//  out_mode    out  2           mode captured with the held result
//  xfer_cnt    out  CNT_W       count of accepted input transfers
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_shares=0, out_mode=00, xfer_cnt=0.
//  - Handshake and timing:
//    - in_ready = !out_valid | out_ready (combinational; single-entry pipeline register).
//    - Accept when in_valid & in_ready: out_shares and out_mode load on that edge; out_valid=1 the next cycle.
//    - Latency is 1 cycle; throughput is 1 transfer per cycle with out_ready held high.
//    - Output handshake without a new accept: out_valid clears.
//    - Output handshake and accept in the same cycle: the new result replaces the old one; out_valid stays 1.
//  - Stall: while out_valid & !out_ready, out_shares and out_mode hold bit-stable and in_ready=0.
//  - mode_i is sampled only on accept; changes at any other time are ignored.
//  - Per-nibble map, x -> y, every share (bit 3 = MSB):
//    - 01 input:  y = {x0^x2, x3, x0, x1}
//    - 10 output: y = {x1, x2^x3, x0, x2}; share OUT_CONST_SHARE has y3 inverted.
//    - 11 middle: y = {x0^x2, x0, x1, x1^x3}; share MID_CONST_SHARE has y3 inverted.
//    - 00 bypass: y = x; no constant.
//  - Result logic is a pure function of the same share only; no cross-share gates before the register.
//  - xfer_cnt increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
//  - in_valid while in_ready=0 is not consumed; the source must hold its data.
//  - A reset mid-stall discards the held result; no output handshake occurs for it.
// TESTING
//  - Reset: rst_n=0 mid-stream -> out_valid=0, out_shares=0, xfer_cnt=0 immediately, without waiting for a clk edge.
//  - Mode 01, SHARES=3, every nibble of share 0 = 4'b0101, others 0 ->
//    share 0 nibbles = 4'b0010; shares 1 and 2 = 0; out_valid 1 cycle after accept.
//  - Mode 10, all shares 0 -> share 2 nibbles = 4'b1000, shares 0-1 = 0.
//    Mode 11, all 0 -> share 0 nibbles = 4'b1000, others 0.
//  - Mode 11, share 1 nibble = 4'b1010, others 0 -> share 1 = 4'b0010, share 0 = 4'b1000.
//    The XOR of shares equals the unshared middle affine of 4'b1010.
//  - Stall: out_ready=0 for 5 cycles while in_valid=1 and in_shares/mode_i toggle ->
//    in_ready=0, out_shares and out_mode stable; out_ready=1 -> new data accepted the same cycle.
//  - Stream: 2^CNT_W+3 back-to-back transfers with out_ready=1 -> one output per cycle, xfer_cnt=3.
//    Random shares checked against the reference model per mode.

Source files
------------

// File: rtl/midori_affine_stage.sv
// Registered N-nibble, d-share Midori affine layer with a single-entry valid/ready
// pipeline register; each share is mapped independently, constant added to one share.
module midori_affine_stage #(
    parameter int NIBBLES         = 16,
    parameter int SHARES          = 3,
    parameter int OUT_CONST_SHARE = SHARES - 1,
    parameter int MID_CONST_SHARE = 0,
    parameter int CNT_W           = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    mode_i,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SHARES*4*NIBBLES-1:0]   in_shares,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SHARES*4*NIBBLES-1:0]   out_shares,
    output logic [1:0]                    out_mode,
    output logic [CNT_W-1:0]              xfer_cnt
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_IN     = 2'b01,
        MODE_OUT    = 2'b10,
        MODE_MID    = 2'b11
    } mode_t;

    mode_t                 mode_sel;
    logic                  accept;
    logic [SHARES*W-1:0]   next_shares;

    function automatic logic [3:0] affine_nib(input logic [3:0] x, input mode_t m,
                                              input logic add_const);
        logic [3:0] y;
        case (m)
            MODE_IN:  y = {x[0] ^ x[2], x[3], x[0], x[1]};
            MODE_OUT: y = {x[1], x[2] ^ x[3], x[0], x[2]};
            MODE_MID: y = {x[0] ^ x[2], x[0], x[1], x[1] ^ x[3]};
            default:  y = x;
        endcase
        y[3] = y[3] ^ add_const;
        return y;
    endfunction

    assign mode_sel = mode_t'(mode_i);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Each nibble depends only on its own share; the constant flag is a static
    // function of share index and mode, so no share mixing precedes the register.
    always_comb begin
        next_shares = '0;
        for (int unsigned s = 0; s < SHARES; s++) begin
            for (int unsigned n = 0; n < NIBBLES; n++) begin
                next_shares[s*W + 4*n +: 4] = affine_nib(
                    in_shares[s*W + 4*n +: 4], mode_sel,
                    ((mode_sel == MODE_OUT) && (int'(s) == OUT_CONST_SHARE)) ||
                    ((mode_sel == MODE_MID) && (int'(s) == MID_CONST_SHARE)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_shares <= '0;
            out_mode   <= MODE_BYPASS;
            xfer_cnt   <= '0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_shares <= next_shares;
                out_mode   <= mode_i;
                xfer_cnt   <= xfer_cnt + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
